serial_subtractor: RTL

- Bit-serial unsigned/two's-complement subtractor: D = A − B, one bit per clock, LSB first.
- Internally reuses a half-subtractor/full-subtractor bit cell and a borrow flip-flop.
- It is the inverse-operation companion to the team's adder cells, for area-constrained datapaths.
- Operands are accepted on a valid/ready request port. Results are returned on a valid/ready response port.

---
 rtl/serial_subtractor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b, one bit per clock, LSB first.
//   A full-subtractor bit cell plus a borrow flop walks the latched operands.
//   After WIDTH cycles the result is presented on a valid/ready response port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE, and not in the cycle right after reset)
//   a, b       minuend / subtrahend
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   diff       (a - b) mod 2^WIDTH
//   borrow     final borrow out, 1 iff a < b unsigned
//   ovf        signed overflow of a - b
//   busy       high in RUN or DONE

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            started;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic            bf;
    logic            a_msb;
    logic            b_msb;
    logic [CW-1:0]   count;
    logic            d_bit;
    logic            bf_next;
    logic            accept;
    logic            last_bit;

    // Full-subtractor bit cell on the current LSBs and the borrow flop.
    always_comb begin
        d_bit   = sa[0] ^ sb[0] ^ bf;
        bf_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
    end

    assign accept   = in_valid && in_ready;
    assign last_bit = (count == LAST);

    // Holds in_ready low until the first clock edge after reset release,
    // since IDLE alone would raise it as soon as rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = started;
                if (in_valid && started) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand/result shift registers, borrow flop, bit counter and
    // the registered result outputs, which load only on the final RUN cycle.
    // The counter is not advanced on the last bit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bf     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            count  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa    <= a;
                        sb    <= b;
                        sd    <= '0;
                        bf    <= 1'b0;
                        count <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sd <= {d_bit, sd[WIDTH-1:1]};
                    bf <= bf_next;
                    if (last_bit) begin
                        diff   <= {d_bit, sd[WIDTH-1:1]};
                        borrow <= bf_next;
                        ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
